// File: rtl/enigma_step_ctrl_if.sv
// Handshake and shared-encoder bus of the Enigma stepping controller.
//   key_*  : keypress handshake into the controller
//   out_*  : lamp handshake out of the controller
//   enc_*  : request to / combinational return from the shared encode unit
// The slave modport is the controller. The master modport is the environment:
// the keyboard, the lamp board and the encode unit.
interface enigma_step_ctrl_if;
    logic       key_valid;
    logic [4:0] key_code;
    logic       key_ready;

    logic       out_valid;
    logic [4:0] out_code;
    logic       out_ready;

    logic [4:0] enc_in;
    logic [4:0] enc_rotor;
    logic [4:0] enc_ring;
    logic [2:0] enc_type;
    logic       enc_rev;
    logic [4:0] enc_out;

    modport slave (
        input  key_valid, key_code, out_ready, enc_out,
        output key_ready, out_valid, out_code,
               enc_in, enc_rotor, enc_ring, enc_type, enc_rev
    );

    modport master (
        output key_valid, key_code, out_ready, enc_out,
        input  key_ready, out_valid, out_code,
               enc_in, enc_rotor, enc_ring, enc_type, enc_rev
    );
endinterface

// File: rtl/enigma_step_ctrl.sv
// Enigma stepping/sequencing controller.
// A keypress steps the rotors. The character is then walked through one shared
// encode unit, one pass per cycle, in this order:
//   right, middle, left, reflector, left, middle, right (reverse direction).
// The result is presented on the lamp handshake.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   cfg_load, cfg_*      : rotor type/ring/start position load (IDLE only)
//   pos_l/m/r            : current rotor positions
//   bus (slave)          : key/lamp handshakes and shared encode-unit bus
module enigma_step_ctrl #(
    parameter logic [2:0] REFL_TYPE = 3'd5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_load,
    input  logic [2:0] cfg_type_l,
    input  logic [2:0] cfg_type_m,
    input  logic [2:0] cfg_type_r,
    input  logic [4:0] cfg_ring_l,
    input  logic [4:0] cfg_ring_m,
    input  logic [4:0] cfg_ring_r,
    input  logic [4:0] cfg_pos_l,
    input  logic [4:0] cfg_pos_m,
    input  logic [4:0] cfg_pos_r,
    output logic [4:0] pos_l,
    output logic [4:0] pos_m,
    output logic [4:0] pos_r,
    enigma_step_ctrl_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE, STEP, F_R, F_M, F_L, REFL, B_L, B_M, B_R, OUT
    } state_t;

    typedef enum logic [1:0] {SEL_NONE, SEL_L, SEL_M, SEL_R} rsel_t;

    state_t     state, state_nxt;
    logic [2:0] type_l, type_m, type_r;
    logic [4:0] ring_l, ring_m, ring_r;
    logic [4:0] data;
    logic       bypass;     // current key is 26..31: no stepping, no encoding
    logic       accept;
    logic       pass_en;    // this cycle uses the encode unit
    rsel_t      sel;
    logic       back;
    logic       refl;
    logic       r_at_notch, m_at_notch;

    function automatic logic [4:0] notch_of(input logic [2:0] t);
        case (t)
            3'd0:    notch_of = 5'd16;
            3'd1:    notch_of = 5'd4;
            3'd2:    notch_of = 5'd21;
            3'd3:    notch_of = 5'd9;
            default: notch_of = 5'd25;
        endcase
    endfunction

    function automatic logic [4:0] inc26(input logic [4:0] p);
        inc26 = (p == 5'd25) ? 5'd0 : p + 5'd1;
    endfunction

    // A load request takes priority over a key in the same IDLE cycle.
    assign accept        = (state == IDLE) && !cfg_load && bus.key_valid;
    assign bus.key_ready = (state == IDLE) && !cfg_load;
    assign bus.out_valid = (state == OUT);
    assign bus.out_code  = data;

    // Notches are compared against the positions before this step.
    assign r_at_notch = (pos_r == notch_of(type_r));
    assign m_at_notch = (pos_m == notch_of(type_m));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            type_l <= 3'd0;
            type_m <= 3'd1;
            type_r <= 3'd2;
            ring_l <= '0;
            ring_m <= '0;
            ring_r <= '0;
            pos_l  <= '0;
            pos_m  <= '0;
            pos_r  <= '0;
            data   <= '0;
            bypass <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && cfg_load) begin
                type_l <= cfg_type_l;
                type_m <= cfg_type_m;
                type_r <= cfg_type_r;
                ring_l <= cfg_ring_l;
                ring_m <= cfg_ring_m;
                ring_r <= cfg_ring_r;
                pos_l  <= cfg_pos_l;
                pos_m  <= cfg_pos_m;
                pos_r  <= cfg_pos_r;
            end
            if (accept) begin
                data   <= bus.key_code;
                bypass <= (bus.key_code > 5'd25);
            end
            if (state == STEP && !bypass) begin
                pos_r <= inc26(pos_r);
                // A middle rotor sitting on its notch steps again.
                // This is the double step.
                if (r_at_notch || m_at_notch)
                    pos_m <= inc26(pos_m);
                if (m_at_notch)
                    pos_l <= inc26(pos_l);
            end
            if (pass_en)
                data <= bus.enc_out;
        end
    end

    always_comb begin
        state_nxt = state;
        sel       = SEL_NONE;
        back      = 1'b0;
        refl      = 1'b0;
        case (state)
            IDLE: if (accept) state_nxt = STEP;
            STEP: state_nxt = F_R;
            F_R:  begin state_nxt = F_M;  sel = SEL_R; end
            F_M:  begin state_nxt = F_L;  sel = SEL_M; end
            F_L:  begin state_nxt = REFL; sel = SEL_L; end
            REFL: begin state_nxt = B_L;  refl = 1'b1; end
            B_L:  begin state_nxt = B_M;  sel = SEL_L; back = 1'b1; end
            B_M:  begin state_nxt = B_R;  sel = SEL_M; back = 1'b1; end
            B_R:  begin state_nxt = OUT;  sel = SEL_R; back = 1'b1; end
            OUT:  if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // For a bypassed key the encode bus stays quiet through the pass states.
    assign pass_en = !bypass && ((sel != SEL_NONE) || refl);

    always_comb begin
        bus.enc_in    = '0;
        bus.enc_rotor = '0;
        bus.enc_ring  = '0;
        bus.enc_type  = '0;
        bus.enc_rev   = 1'b0;
        if (pass_en) begin
            bus.enc_in  = data;
            bus.enc_rev = back;
            case (sel)
                SEL_L: begin
                    bus.enc_rotor = pos_l;
                    bus.enc_ring  = ring_l;
                    bus.enc_type  = type_l;
                end
                SEL_M: begin
                    bus.enc_rotor = pos_m;
                    bus.enc_ring  = ring_m;
                    bus.enc_type  = type_m;
                end
                SEL_R: begin
                    bus.enc_rotor = pos_r;
                    bus.enc_ring  = ring_r;
                    bus.enc_type  = type_r;
                end
                default: bus.enc_type = REFL_TYPE;
            endcase
        end
    end

endmodule

// File: doc/enigma_step_ctrl.md
ENIGMA_STEP_CTRL -- requirements
Module: enigma_step_ctrl

Interface
REQ-001 Parameter: REFL_TYPE, 3'd5, rotor_type code that the shared encode unit treats as the reflector.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 cfg_load  input  1  load configuration (honoured in IDLE only).
REQ-005 cfg_type_l/m/r  input  3 each  rotor types (0..4 = I..V).
REQ-006 cfg_ring_l/m/r  input  5 each  ring settings, 0..25.
REQ-007 cfg_pos_l/m/r  input  5 each  start positions, 0..25.
REQ-008 key_valid, key_code[4:0] input; key_ready output  keypress handshake.
REQ-009 out_valid, out_code[4:0] output; out_ready input  lamp handshake.
REQ-010 pos_l, pos_m, pos_r  output  5 each  current rotor positions.
REQ-011 enc_in[4:0], enc_rotor[4:0], enc_ring[4:0], enc_type[2:0], enc_rev  outputs to the one shared encode unit; enc_out[4:0] input, combinational return in the same cycle.

Function
REQ-012 FSM states: IDLE, STEP, F_R, F_M, F_L, REFL, B_L, B_M, B_R, OUT; one cycle each except IDLE and OUT.
REQ-013 key_ready = 1 only in IDLE with cfg_load = 0; key accepted when key_valid & key_ready -> STEP, key_code captured into data register.
REQ-014 IDLE & cfg_load: all cfg_* latched into type/ring/position registers; no key accepted that cycle; cfg_load outside IDLE ignored.
REQ-015 STEP, key_code <= 25: notches I=16, II=4, III=21, IV=9, V=25, evaluated on pre-step positions; right always +1; middle +1 if right at notch or middle at notch (double step); left +1 if middle at notch; each position wraps 25 -> 0.
REQ-016 STEP, key_code 26..31: no stepping; all pass states skipped in effect (data register unchanged); out_code = key_code; latency unchanged.
REQ-017 Pass states drive enc_* and register enc_out into data register at end of cycle: F_R/F_M/F_L = right/middle/left rotor, enc_rev = 0; REFL enc_type = REFL_TYPE, enc_rotor = 0, enc_ring = 0, enc_rev = 0; B_L/B_M/B_R = left/middle/right, enc_rev = 1.
REQ-018 enc_rotor uses post-step position; enc_in = data register; enc_* = 0 in IDLE, STEP, OUT.
REQ-019 B_R -> OUT; out_valid = 1 in OUT only; out_code = data register, stable while out_valid & !out_ready.
REQ-020 OUT & out_ready -> IDLE; out_valid first high 9 cycles after the acceptance edge; minimum key-to-key period 10 cycles.
REQ-021 pos_l/m/r reflect position registers at all times; they update on the STEP edge only (or cfg load).

Reset
REQ-022 rst_n low: immediately state = IDLE, out_valid = 0, out_code = 0, enc_* = 0, positions = 0, rings = 0, types l/m/r = 0/1/2.
REQ-023 Reset asserted mid-sequence discards the in-flight character; no out_valid produced for it; key_ready = 1 from the first edge after release.

Verification
REQ-024 Types I/II/III, REFL_TYPE = reflector B, rings 0, positions 0/0/0, five keys code 0 -> out_code 1,3,25,6,14 (AAAAA -> BDZGO); final pos 0/0/5.
REQ-025 Double step: types I/II/III, positions 0/3/20, three keys -> pos after each 0/3/21, 0/4/22, 1/5/23.
REQ-026 Wrap: positions 25/25/25, rotors V/V/V, one key -> pos 0/0/0 (all three step and wrap).
REQ-027 Backpressure: out_ready held low 5 cycles in OUT -> out_valid and out_code constant, key_ready = 0, positions unchanged; release -> IDLE next cycle.
REQ-028 Collision/illegal: cfg_load with key_valid in IDLE -> config loaded, key not accepted until next cycle; key_code 27 -> out_code 27 after 9 cycles, positions unchanged.
REQ-029 rst_n pulsed low during F_M -> out_valid never asserts for that key, positions return to 0/0/0, fresh key then processed normally.
